// File: rtl/roulette_spin.sv
// roulette_spin: one-hot "roulette" ring that rotates at a rate set by a
// free-running prescaler. A step is taken whenever a selected prescaler bit
// (the tap) falls, so ring advances are 2^(tap+1) cycles apart.
//
// Optional feature, selected by the macro ROULETTE_DECEL_EN:
//   defined   - stop enters a deceleration phase. The ring is slowed by 2x
//               after every DECEL_STEPS advances, over four levels, and then
//               the block returns to idle.
//   undefined - stop returns to idle immediately.
//
// Parameters:
//   RING_W      number of ring positions (2..32)
//   CNT_W       prescaler counter width
//   TAP_BASE    prescaler tap bit for sel=0 (6..CNT_W-4)
//   DECEL_STEPS ring advances per deceleration level (1..255)
//
// Ports:
//   clk    in   single clock, rising edge
//   nrst   in   asynchronous active-low reset
//   start  in   begin spinning (ignored while busy)
//   stop   in   end spinning (ignored while idle)
//   sel    in   speed select; 0 is slowest, 3 is fastest (latched on start)
//   dir    in   0 rotates up, 1 rotates down (latched on start)
//   ring   out  one-hot current position
//   pos    out  binary index of the set ring bit
//   busy   out  high whenever the FSM is not idle
//   done   out  one-cycle pulse on return to idle after a stop
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ring frozen, prescaler held at 0, waiting for start
// SPIN  | ring advancing at the latched speed
// DECEL | slowing down level by level after stop (ROULETTE_DECEL_EN only)

module roulette_spin #(
   parameter int RING_W      = 6,
   parameter int CNT_W       = 32,
   parameter int TAP_BASE    = 25,
   parameter int DECEL_STEPS = 4
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic                      start,
   input  logic                      stop,
   input  logic [1:0]                sel,
   input  logic                      dir,
   output logic [RING_W-1:0]         ring,
   output logic [$clog2(RING_W)-1:0] pos,
   output logic                      busy,
   output logic                      done
);

   localparam int POS_W = $clog2(RING_W);
   // Index width matched to the prescaler so any tap can address it directly.
   localparam int TAP_W = $clog2(CNT_W);

   if (RING_W < 2 || RING_W > 32) begin : g_bad_ring_w
      $error("roulette_spin: RING_W out of range");
   end
   if (TAP_BASE < 6 || TAP_BASE > CNT_W - 4) begin : g_bad_tap_base
      $error("roulette_spin: TAP_BASE out of range");
   end
   if (DECEL_STEPS < 1 || DECEL_STEPS > 255) begin : g_bad_decel_steps
      $error("roulette_spin: DECEL_STEPS out of range");
   end

`ifdef ROULETTE_DECEL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1, DECEL = 2'd2} state_t;
   localparam logic [7:0] DS_LAST = 8'(DECEL_STEPS - 1);
   logic [1:0] lvl, lvl_nxt;
   logic [7:0] scnt, scnt_nxt;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SPIN = 2'd1} state_t;
`endif

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [1:0]         sel_q, sel_nxt;
   logic               dir_q, dir_nxt;
   logic               prev_tap, prev_nxt;
   logic [RING_W-1:0]  ring_nxt;
   logic               done_nxt;
   logic [TAP_W-1:0]   tap, tap_nxt;
   logic               step;

   function automatic logic [TAP_W-1:0] tap_of(input logic [1:0] s, input logic [1:0] l);
      return TAP_W'(TAP_BASE) - TAP_W'({s, 1'b0}) + TAP_W'(l);
   endfunction

`ifdef ROULETTE_DECEL_EN
   assign tap = tap_of(sel_q, lvl);
`else
   assign tap = tap_of(sel_q, 2'b00);
`endif

   assign busy = (state != IDLE);
   // Falling edge of the tap bit.
   assign step = busy & prev_tap & ~cnt[tap];

   always_comb begin
      pos = '0;
      for (int i = 0; i < RING_W; i++) begin
         if (ring[i]) pos = pos | POS_W'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      sel_nxt   = sel_q;
      dir_nxt   = dir_q;
      done_nxt  = 1'b0;
      ring_nxt  = ring;
`ifdef ROULETTE_DECEL_EN
      lvl_nxt   = lvl;
      scnt_nxt  = scnt;
`endif

      if (step) begin
         if (dir_q) ring_nxt = {ring[0], ring[RING_W-1:1]};
         else       ring_nxt = {ring[RING_W-2:0], ring[RING_W-1]};
      end

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SPIN;
               sel_nxt   = sel;
               dir_nxt   = dir;
            end
         end
         SPIN: begin
            if (stop) begin
`ifdef ROULETTE_DECEL_EN
               state_nxt = DECEL;
               lvl_nxt   = 2'd0;
               scnt_nxt  = 8'd0;
`else
               state_nxt = IDLE;
               done_nxt  = 1'b1;
`endif
            end
         end
`ifdef ROULETTE_DECEL_EN
         DECEL: begin
            if (step) begin
               if (scnt == DS_LAST) begin
                  scnt_nxt = 8'd0;
                  if (lvl == 2'd3) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                     lvl_nxt   = 2'd0;
                  end else begin
                     lvl_nxt = lvl + 2'd1;
                  end
               end else begin
                  scnt_nxt = scnt + 8'd1;
               end
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase

      if (state == IDLE || state_nxt == IDLE) cnt_nxt = '0;
      else                                    cnt_nxt = cnt + CNT_W'(1);

`ifdef ROULETTE_DECEL_EN
      tap_nxt = tap_of(sel_nxt, lvl_nxt);
`else
      tap_nxt = tap_of(sel_nxt, 2'b00);
`endif
      // When the tap moves, seed the history with the new bit so the switch
      // itself never looks like a falling edge.
      if (tap_nxt != tap) prev_nxt = cnt_nxt[tap_nxt];
      else                prev_nxt = cnt[tap];
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         cnt      <= '0;
         sel_q    <= 2'd0;
         dir_q    <= 1'b0;
         prev_tap <= 1'b0;
         ring     <= RING_W'(1);
         done     <= 1'b0;
`ifdef ROULETTE_DECEL_EN
         lvl      <= 2'd0;
         scnt     <= 8'd0;
`endif
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sel_q    <= sel_nxt;
         dir_q    <= dir_nxt;
         prev_tap <= prev_nxt;
         ring     <= ring_nxt;
         done     <= done_nxt;
`ifdef ROULETTE_DECEL_EN
         lvl      <= lvl_nxt;
         scnt     <= scnt_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_roulette_spin.sv
// Directed bench for roulette_spin (RING_W=6, CNT_W=12, TAP_BASE=6,
// DECEL_STEPS=2). Builds with or without ROULETTE_DECEL_EN.
// Edge numbers count from the start edge (edge 0); outputs are sampled 1
// time unit after each rising edge.

module tb_roulette_spin;

   localparam int RING_W      = 6;
   localparam int CNT_W       = 12;
   localparam int TAP_BASE    = 6;
   localparam int DECEL_STEPS = 2;

   logic       clk = 1'b0;
   logic       nrst, start, stop, dir;
   logic [1:0] sel;
   logic [5:0] ring;
   logic [2:0] pos;
   logic       busy, done;

   int n_cmp = 0;
   int n_bad = 0;
   int e;
   int exp_pos;

`ifdef ROULETTE_DECEL_EN
   // Edges after the stop (asserted while cnt=21) at which the ring moves.
   int adv_edges[8] = '{23, 25, 29, 33, 41, 49, 65, 81};
`endif

   always #5 clk = ~clk;

   roulette_spin #(
      .RING_W(RING_W), .CNT_W(CNT_W), .TAP_BASE(TAP_BASE), .DECEL_STEPS(DECEL_STEPS)
   ) dut (
      .clk(clk), .nrst(nrst), .start(start), .stop(stop), .sel(sel), .dir(dir),
      .ring(ring), .pos(pos), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_state(input string tag, input int exp_busy, input int exp_done);
      chk($sformatf("%s_ring", tag), 32'(ring), 32'(1) << exp_pos);
      chk($sformatf("%s_pos", tag), 32'(pos), 32'(exp_pos));
      chk($sformatf("%s_busy", tag), 32'(busy), 32'(exp_busy));
      chk($sformatf("%s_done", tag), 32'(done), 32'(exp_done));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   function automatic int next_pos(input int p, input bit d);
      if (d) return (p == 0) ? RING_W - 1 : p - 1;
      else   return (p == RING_W - 1) ? 0 : p + 1;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b1; start = 1'b0; stop = 1'b0; sel = 2'd0; dir = 1'b0;
      exp_pos = 0; e = 0;
      #1 nrst = 1'b0;
      #1 chk_state("reset", 0, 0);
      repeat (2) tick();
      nrst = 1'b1;
      repeat (2) tick();
      chk_state("idle", 0, 0);

      // sel=3 (tap 0), dir up: first move on edge 3, then every 2 edges.
      // A start with different sel/dir before edge 9 must be ignored.
      sel = 2'd3; dir = 1'b0; start = 1'b1; e = -1;
      tick();
      start = 1'b0;
      chk_state("a_e0", 1, 0);
      for (int k = 1; k <= 21; k++) begin
         if (k == 9) begin start = 1'b1; sel = 2'd0; dir = 1'b1; end
         tick();
         start = 1'b0; sel = 2'd3; dir = 1'b0;
         if (k >= 3 && (k - 3) % 2 == 0) exp_pos = next_pos(exp_pos, 1'b0);
         chk_state($sformatf("a_e%0d", e), 1, 0);
      end

      stop = 1'b1;
`ifdef ROULETTE_DECEL_EN
      for (int k = 22; k <= 81; k++) begin
         bit moves;
         tick();
         stop = 1'b0;
         moves = 1'b0;
         foreach (adv_edges[j]) if (adv_edges[j] == k) moves = 1'b1;
         if (moves) exp_pos = next_pos(exp_pos, 1'b0);
         chk_state($sformatf("dec_e%0d", e), (k < 81) ? 1 : 0, (k == 81) ? 1 : 0);
      end
      for (int k = 82; k <= 89; k++) begin
         tick();
         chk_state($sformatf("dec_idle_e%0d", e), 0, 0);
      end
`else
      tick();
      stop = 1'b0;
      chk_state("stop_e22", 0, 1);
      for (int k = 23; k <= 30; k++) begin
         tick();
         chk_state($sformatf("stop_idle_e%0d", e), 0, 0);
      end
`endif

      // Reset in the middle of a spin, between clock edges.
      sel = 2'd3; dir = 1'b0; start = 1'b1; e = -1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 3) exp_pos = next_pos(exp_pos, 1'b0);
         chk_state($sformatf("c_e%0d", e), 1, 0);
      end
      nrst = 1'b0;
      exp_pos = 0;
      #1 chk_state("c_async_rst", 0, 0);
      repeat (2) tick();
      chk_state("c_in_rst", 0, 0);
      nrst = 1'b1;
      stop = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_state($sformatf("c_idle_stop%0d", k), 0, 0);
      end
      stop = 1'b0;

      // start+stop together in idle -> spin; sel=0 (tap 6), dir down.
      sel = 2'd0; dir = 1'b1; start = 1'b1; stop = 1'b1; e = -1;
      tick();
      start = 1'b0; stop = 1'b0;
      chk_state("b_e0", 1, 0);
      for (int k = 1; k <= 260; k++) begin
         tick();
         if (k == 129 || k == 257) exp_pos = next_pos(exp_pos, 1'b1);
         chk_state($sformatf("b_e%0d", e), 1, 0);
      end
      chk("b_final_pos", 32'(pos), 32'd4);

      nrst = 1'b0;
      exp_pos = 0;
      #1 chk_state("end_rst", 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/roulette_spin.md
ROULETTE_SPIN -- requirements
Module: roulette_spin

Interface
REQ-001 SHALL have parameter RING_W, default 6, number of one-hot ring positions (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 32, prescaler counter width.
REQ-003 SHALL have parameter TAP_BASE, default 25, prescaler tap bit for sel=0 (legal range 6..CNT_W-4).
REQ-004 SHALL have parameter DECEL_STEPS, default 4, ring advances per deceleration level (legal range 1..255).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state SHALL be on its rising edge.
REQ-006 SHALL have port nrst, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, request to begin spinning.
REQ-008 SHALL have port stop, input, 1 bit, request to end spinning.
REQ-009 SHALL have port sel, input, 2 bits, speed select; 0 is slowest and 3 is fastest.
REQ-010 SHALL have port dir, input, 1 bit, rotation direction: 0 rotates up, 1 rotates down.
REQ-011 SHALL have port ring, output, RING_W bits, one-hot current position.
REQ-012 SHALL have port pos, output, clog2(RING_W) bits, binary index of the set ring bit.
REQ-013 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit, one-cycle pulse on return to IDLE after a stop.

Function
REQ-015 SHALL implement states IDLE, SPIN and DECEL, with busy = (state != IDLE).
REQ-016 In IDLE, start SHALL latch sel and dir into sel_q/dir_q, clear the prescaler cnt to 0, and enter SPIN at that edge.
REQ-017 cnt SHALL increment by 1 (mod 2^CNT_W) each cycle while busy and SHALL hold 0 in IDLE.
REQ-018 The tap index SHALL be TAP_BASE - 2*sel_q + lvl, where lvl is the 2-bit deceleration level (0 outside DECEL).
REQ-019 A step SHALL be flagged in any cycle where cnt[tap] = 0 and the registered previous cnt[tap] = 1.
REQ-020 On a step, ring SHALL advance one position on the next edge, then every 2^(tap+1) cycles while tap is unchanged.
REQ-021 After a start edge the first ring advance SHALL occur on the 2^(tap+1)+1-th edge.
REQ-022 The previous-tap register SHALL be reloaded with the new tap bit in any cycle where tap changes, so no step is flagged that cycle.
REQ-023 With dir_q=0, ring bit i SHALL move to bit i+1 and bit RING_W-1 SHALL wrap to bit 0.
REQ-024 With dir_q=1, ring SHALL rotate the opposite way, with bit 0 wrapping to bit RING_W-1.
REQ-025 pos SHALL always equal the index of the set ring bit, and ring SHALL hold its value in IDLE.
REQ-026 start while busy SHALL be ignored, and stop while IDLE SHALL be ignored.
REQ-027 If start and stop are asserted together in IDLE, start SHALL win; if together in SPIN, stop SHALL win.
REQ-028 A step and stop in the same cycle SHALL both take effect: the ring advances and the state transitions.
REQ-029 sel and dir changes while busy SHALL have no effect until the next start.

Reset
REQ-030 On nrst low, asynchronously: state=IDLE, ring=1 (bit 0), pos=0, cnt=0, lvl=0, step counter=0, previous-tap register=0, busy=0, done=0.
REQ-031 Reset asserted mid-spin SHALL abort without a done pulse; after release the block SHALL stay in IDLE until start.

Configuration
REQ-032 With macro ROULETTE_DECEL_EN defined, stop in SPIN SHALL enter DECEL with lvl=0 and the step counter at 0.
REQ-033 In DECEL, each DECEL_STEPS steps SHALL increment lvl (slowing the ring by 2x) and clear the step counter.
REQ-034 In DECEL with lvl=3, DECEL_STEPS further steps SHALL return the block to IDLE and pulse done, for 4*DECEL_STEPS advances in total.
REQ-035 With ROULETTE_DECEL_EN undefined, DECEL, lvl and the step counter SHALL be absent.
REQ-036 With ROULETTE_DECEL_EN undefined, stop in SPIN SHALL go to IDLE at that edge and pulse done on the following cycle.

Verification (bench parameters: RING_W=6, CNT_W=12, TAP_BASE=6, DECEL_STEPS=2)
REQ-037 Reset, then start with sel=3 and dir=0 -> busy=1; ring=000010 on edge 3 after start, then advances every 2 cycles and wraps 100000 -> 000001.
REQ-038 Start with sel=0 and dir=1 -> first advance (000001 -> 100000) on edge 129, then every 128 cycles; pos goes 0 -> 5 -> 4.
REQ-039 With ROULETTE_DECEL_EN, stop with sel=3 -> exactly 8 further advances, spaced 2,2,4,4,8,8,16,16 cycles; then busy=0 and done is high for 1 cycle.
REQ-040 Without ROULETTE_DECEL_EN, stop during SPIN -> busy=0 next cycle, done high for 1 cycle, ring frozen thereafter.
REQ-041 Boundaries -> start+stop together in IDLE enters SPIN; start during SPIN is ignored; nrst low mid-spin gives ring=000001, busy=0, done=0 immediately with no clock edge.
